// File: rtl/iobs_pkg.sv
// Shared types for the IO-bus slave write queue: FSM encodings, queue entry layout
// and a constant log2 helper.
package iobs_pkg;

  localparam int IOBS_AW = 23;
  localparam int IOBS_DW = 16;

  typedef enum logic [2:0] {IDLE, POST, DRAIN, WAIT, ERR, DONE} sstate_e;
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_ACT} mstate_e;

  // Entry layout at the default widths; the top re-declares it at its own AW/DW.
  typedef struct packed {
    logic [IOBS_AW-1:0] a;
    logic [IOBS_DW-1:0] d;
    logic               u;
    logic               l;
    logic               rw;
  } entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/iobs_wq_fifo.sv
// Posted-write ring buffer; a push while full is accepted when a pop lands in the same cycle.
module iobs_wq_fifo
  import iobs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [EW-1:0] din_i,
  input  logic          pop_i,
  output logic [EW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rp_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/iobs_wq.sv
// IO-bus slave with a DEPTH-entry posted-write queue; reads and non-posted writes
// wait for the queue to drain and go out through a single direct entry.
module iobs_wq
  import iobs_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int AW          = IOBS_AW,
  parameter int DW          = IOBS_DW,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK_FSB,
  input  logic          RES,
  input  logic          BACT,
  input  logic          IOCS,
  input  logic          IOPWCS,
  input  logic          nWE_FSB,
  input  logic          nUDS_FSB,
  input  logic          nLDS_FSB,
  input  logic [AW-1:0] A_FSB,
  input  logic [DW-1:0] D_FSB,
  output logic          Ready,
  output logic          BERR,
  output logic          nDinOE,
  output logic          IOREQ,
  output logic [AW-1:0] IOA,
  output logic [DW-1:0] IOD,
  output logic          IORW,
  output logic          IOU,
  output logic          IOL,
  input  logic          IOACT,
  input  logic          IOBERR,
  output logic          Full,
  output logic          Empty
);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    logic          rw;
  } ent_t;
  localparam int EW = $bits(ent_t);

  sstate_e s_q, s_d;
  mstate_e m_q, m_d;
  ent_t    cur_q, cur_d, dir_q, dir_d, fsb_ent;
  logic    cur_dir_q, cur_dir_d, dir_vld_q, dir_vld_d;
  logic    sticky_q, sticky_d, ready_q, ready_d, berr_q, berr_d, dinoe_n_q, dinoe_n_d;
  logic    bact_q, start;
  logic [SYNC_STAGES-1:0] act_sync_q, ber_sync_q;
  logic    acts, bers, acts_d_q, bers_d_q, act_rise, act_fall;
  logic    push, pop, dir_load, dir_done, set_sticky, clr_sticky;
  logic    fifo_full, fifo_empty;
  logic [EW-1:0] fifo_dout;

  assign fsb_ent = {A_FSB, D_FSB, ~nUDS_FSB, ~nLDS_FSB, nWE_FSB};
  assign start   = BACT & ~bact_q & IOCS;
  assign acts    = act_sync_q[SYNC_STAGES-1];
  assign bers    = ber_sync_q[SYNC_STAGES-1];
  assign act_rise = acts & ~acts_d_q;
  assign act_fall = ~acts & acts_d_q;

  iobs_wq_fifo #(.DEPTH(DEPTH), .EW(EW)) u_fifo (
    .clk     (CLK_FSB),
    .rst     (RES),
    .push_i  (push),
    .din_i   ({fsb_ent[EW-1:1], 1'b0}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Master: queue head has priority; the direct entry is only loaded once the queue is empty.
  always_comb begin
    m_d        = m_q;
    cur_d      = cur_q;
    cur_dir_d  = cur_dir_q;
    pop        = 1'b0;
    dir_done   = 1'b0;
    set_sticky = 1'b0;
    case (m_q)
      M_IDLE: begin
        if (!fifo_empty) begin
          cur_d     = ent_t'(fifo_dout);
          cur_dir_d = 1'b0;
          m_d       = M_REQ;
        end else if (dir_vld_q) begin
          cur_d     = dir_q;
          cur_dir_d = 1'b1;
          m_d       = M_REQ;
        end
      end
      M_REQ: if (act_rise) m_d = M_ACT;
      M_ACT: begin
        if (act_fall) begin
          m_d = M_IDLE;
          if (cur_dir_q) dir_done = 1'b1;
          else begin
            pop        = 1'b1;
            set_sticky = bers_d_q;
          end
        end
      end
      default: m_d = M_IDLE;
    endcase
  end

  always_comb begin
    s_d        = s_q;
    ready_d    = ready_q;
    berr_d     = berr_q;
    dinoe_n_d  = dinoe_n_q;
    push       = 1'b0;
    dir_load   = 1'b0;
    clr_sticky = 1'b0;
    case (s_q)
      IDLE: begin
        if (start) begin
          if (sticky_q)                 s_d = ERR;
          else if (!nWE_FSB && IOPWCS)  s_d = POST;
          else                          s_d = DRAIN;
        end
      end
      POST: begin
        if (!BACT) s_d = IDLE;
        else if (!fifo_full || pop) begin
          push    = 1'b1;
          ready_d = 1'b1;
          s_d     = DONE;
        end
      end
      DRAIN: begin
        if (!BACT) s_d = IDLE;
        else if (fifo_empty && m_q == M_IDLE) begin
          dir_load = 1'b1;
          s_d      = WAIT;
        end
      end
      WAIT: begin
        if (!BACT) dinoe_n_d = 1'b1;
        else if (m_q == M_REQ && act_rise && cur_dir_q && cur_q.rw) dinoe_n_d = 1'b0;
        // An aborted cycle still lets the transfer finish, but its result is dropped.
        if (dir_done) begin
          if (BACT) begin
            ready_d = ~bers_d_q;
            berr_d  = bers_d_q;
            s_d     = DONE;
          end else begin
            s_d = IDLE;
          end
        end
      end
      ERR: begin
        berr_d     = 1'b1;
        clr_sticky = 1'b1;
        s_d        = DONE;
      end
      DONE: begin
        if (!BACT) begin
          ready_d   = 1'b0;
          berr_d    = 1'b0;
          dinoe_n_d = 1'b1;
          s_d       = IDLE;
        end
      end
      default: s_d = IDLE;
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    dir_vld_d = dir_vld_q;
    if (dir_load) begin
      dir_d     = fsb_ent;
      dir_vld_d = 1'b1;
    end else if (dir_done) begin
      dir_vld_d = 1'b0;
    end
    sticky_d = (sticky_q & ~clr_sticky) | set_sticky;
  end

  always_ff @(posedge CLK_FSB or posedge RES) begin
    if (RES) begin
      s_q        <= IDLE;
      m_q        <= M_IDLE;
      cur_q      <= '0;
      cur_dir_q  <= 1'b0;
      dir_q      <= '0;
      dir_vld_q  <= 1'b0;
      sticky_q   <= 1'b0;
      ready_q    <= 1'b0;
      berr_q     <= 1'b0;
      dinoe_n_q  <= 1'b1;
      bact_q     <= 1'b0;
      act_sync_q <= '0;
      ber_sync_q <= '0;
      acts_d_q   <= 1'b0;
      bers_d_q   <= 1'b0;
    end else begin
      s_q        <= s_d;
      m_q        <= m_d;
      cur_q      <= cur_d;
      cur_dir_q  <= cur_dir_d;
      dir_q      <= dir_d;
      dir_vld_q  <= dir_vld_d;
      sticky_q   <= sticky_d;
      ready_q    <= ready_d;
      berr_q     <= berr_d;
      dinoe_n_q  <= dinoe_n_d;
      bact_q     <= BACT;
      act_sync_q <= {act_sync_q[SYNC_STAGES-2:0], IOACT};
      ber_sync_q <= {ber_sync_q[SYNC_STAGES-2:0], IOBERR};
      acts_d_q   <= acts;
      // IOBERR is taken from the last sample where ACT was still high.
      bers_d_q   <= bers;
    end
  end

  assign Ready  = ready_q;
  assign BERR   = berr_q;
  assign nDinOE = dinoe_n_q;
  assign IOREQ  = (m_q == M_REQ);
  assign IOA    = cur_q.a;
  assign IOD    = cur_q.d;
  assign IORW   = cur_q.rw;
  assign IOU    = cur_q.u;
  assign IOL    = cur_q.l;
  assign Full   = fifo_full;
  assign Empty  = fifo_empty;

endmodule

// File: doc/iobs_wq.md
Name: iobs_wq

Overview:
- Parametrised successor to the fixed two-level IO-bus slave write latch scheme.
- Sits between the FSB slave decode (CS/FSB) and the IO bus master (IOBM).
- Holds a DEPTH-entry posted-write queue with internal address/data storage, and serialises reads and non-posted writes behind queued writes.
- Reports the FSB Ready/BERR and sticky posted-write errors.

Parameters:
DEPTH, 4, posted-write queue entries; power of two, >= 2
AW, 23, FSB word-address width (A[AW:1])
DW, 16, data width
SYNC_STAGES, 2, synchroniser flops on IOACT/IOBERR (>= 2)

Ports:
CLK_FSB  in  1  FSB clock; all state on rising edge
RES  in  1  asynchronous active-high reset
BACT  in  1  FSB bus cycle active (AS qualified)
IOCS  in  1  IO space selected
IOPWCS  in  1  IO posted-write-eligible space selected
nWE_FSB  in  1  0 = write
nUDS_FSB, nLDS_FSB  in  1 each  byte strobes, active-low
A_FSB  in  AW  word address
D_FSB  in  DW  write data
Ready  out  1  FSB cycle complete
BERR  out  1  FSB bus error
nDinOE  out  1  read-data buffer OE, active-low
IOREQ  out  1  request to IOBM
IOA  out  AW  IOBM address
IOD  out  DW  IOBM write data
IORW, IOU, IOL  out  1 each  1 = read; upper/lower strobe, active-high
IOACT  in  1  IOBM cycle active (async)
IOBERR  in  1  IOBM bus error (async, valid while IOACT)
Full, Empty  out  1 each  queue status

Behaviour:
- Reset (async, RES=1): queue flushed, count=0, slave FSM=IDLE, master FSM=M_IDLE, sticky error cleared.
- Reset output values: Ready=0, BERR=0, nDinOE=1, IOREQ=0, IOA=0, IOD=0, IORW=0, IOU=0, IOL=0, Full=0, Empty=1.
- Reset mid-cycle: pending and queued transfers are dropped, not completed.
- Start: Start = BACT & ~BACT_d & IOCS (one-cycle pulse).
- Synchroniser: IOACT/IOBERR pass SYNC_STAGES flops; ACTs is the synced IOACT. ACT edges are detected on ACTs.

Slave FSM:
- IDLE, Start:
  - Sticky error set -> ERR.
  - Else write & IOPWCS -> POST.
  - Else -> DRAIN.
- POST:
  - If ~Full, enqueue {A,D,~nUDS,~nLDS,RW=0}, then -> DONE; Ready=1 from the next cycle.
  - If Full, wait; a dequeue and enqueue in the same cycle is legal (count unchanged).
- DRAIN: wait for Empty & master M_IDLE, then load the direct entry -> WAIT.
- WAIT:
  - Master completes the direct entry; Ready=1 on no error, or BERR=1 on IOBERR sampled at ACT fall.
  - nDinOE=0 for reads from ACT rise until BACT falls.
  - Then -> DONE.
- ERR: BERR=1, clear sticky error, -> DONE.
- DONE: hold Ready/BERR/nDinOE until BACT=0, then deassert all three that cycle and -> IDLE.
- BACT falling in POST/DRAIN (aborted cycle): -> IDLE, no enqueue.
- BACT falling in WAIT: the master still completes the transfer; the result is discarded.

Master FSM (priority: queue head, else direct entry):
- M_IDLE, entry available: drive IOA/IOD/IORW/IOU/IOL from the entry, IOREQ=1 -> M_REQ.
- M_REQ: on ACTs rise, IOREQ=0 -> M_ACT. IO outputs are held stable until ACT fall.
- M_ACT, on ACTs fall:
  - Queue entry: dequeue; if IOBERR set, set the sticky error.
  - Direct entry: signal completion.
  - Then -> M_IDLE.
- Back-to-back: a new IOREQ is allowed the cycle after M_IDLE is re-entered.

Queue:
- Ring buffer; pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Full = (count==DEPTH), Empty = (count==0).
- Strict FIFO order; a read is never issued ahead of an older posted write.

Latency:
- Posted write not full: Ready 2 cycles after the BACT rise edge is sampled.

Decomposition:
- Package iobs_pkg:
  - slave state enum {IDLE,POST,DRAIN,WAIT,ERR,DONE};
  - master enum {M_IDLE,M_REQ,M_ACT};
  - entry struct {a[AW], d[DW], u, l, rw};
  - function clog2.
- Sub-module iobs_wq_fifo: ring buffer storage, pointers, count, Full/Empty, with simultaneous push/pop.

Test Plan:
- Single posted write A=0x3FE000, D=0xA5A5, both strobes -> Ready at cycle+2; IOREQ with IOA=0x3FE000, IOD=0xA5A5, IOU=IOL=1, IORW=0; Empty after ACT fall.
- DEPTH=4, five back-to-back posted writes with IOACT stalled -> Full after four; fifth Ready held off until the first ACT fall; issue order preserved 1..5.
- Two posted writes then a read -> read IOREQ only after both writes dequeue; nDinOE=0 during the read ACT; Ready at completion.
- Posted write with IOBERR=1 at ACT fall -> no FSB BERR then; next IOCS cycle gets BERR=1 with no IOREQ; the following cycle proceeds normally.
- Simultaneous enqueue and dequeue at count=DEPTH-1, pointers at wrap index 3->0 -> count unchanged, data intact.
- RES pulse with 3 queued entries mid-ACT -> all outputs at reset values immediately, Empty=1, no further IOREQ.
